// File: rtl/adr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adr_pkg                                                |
// | Description : Shared op encodings and sequencer states for the       |
// |               65C02 address-bus half unit.                           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package adr_pkg;

    // Address operations selected by microcode while the unit is in RUN
    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_ONE  = 4'b0001;
    localparam logic [3:0] OP_ONES = 4'b0010;
    localparam logic [3:0] OP_HOLD = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_DEC  = 4'b0101;
    localparam logic [3:0] OP_PC   = 4'b0110;
    localparam logic [3:0] OP_DB   = 4'b0111;
    localparam logic [3:0] OP_ABDB = 4'b1000;
    localparam logic [3:0] OP_SAV  = 4'b1001;
    localparam logic [3:0] OP_PCDB = 4'b1010;

    // Vector sequencer states
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        VEC0 = 2'd1,
        VEC1 = 2'd2
    } state_t;

endpackage : adr_pkg
`default_nettype wire

// File: rtl/adr_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adr_add                                                |
// | Description : WIDTH-bit adder A + B + CI with carry-out.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module adr_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    // One extra bit on each operand captures the carry out of the MSB
    always_comb begin
        {co, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    end

endmodule : adr_add
`default_nettype wire

// File: rtl/adr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adr_unit                                               |
// | Description : One half of the 65C02 address bus: next-address mux    |
// |               and adder, AB/PC/SAV registers, registered carry for   |
// |               chaining, and a two-cycle interrupt vector sequencer.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module adr_unit
    import adr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_PC   = '0,
    parameter logic [WIDTH-1:0] VEC_BASE = WIDTH'(8'hFA),
    parameter int unsigned      VEC_INC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CI,
    input  logic [WIDTH-1:0] DB,
    input  logic [3:0]       op,
    input  logic             ld_pc,
    input  logic             inc_pc,
    input  logic             ld_sav,
    input  logic             vec_req,
    input  logic [1:0]       vec_sel,
    output logic [WIDTH-1:0] AD,
    output logic [WIDTH-1:0] AB,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] SAV,
    output logic             CO,
    output logic             CO_Q,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [1:0]       vsel_q,  vsel_d;
    logic [WIDTH-1:0] ab_q,    ab_d;
    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [WIDTH-1:0] sav_q,   sav_d;
    logic             co_q,    co_d;
    logic             busy_q,  busy_d;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    // The single adder shared by every op and by both vector cycles
    adr_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .ci  (add_ci),
        .sum (add_sum),
        .co  (add_co)
    );

    // State register and all datapath flops; reset also aborts a vector fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            vsel_q  <= 2'd0;
            ab_q    <= '0;
            pc_q    <= RST_PC;
            sav_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsel_q  <= vsel_d;
            ab_q    <= ab_d;
            pc_q    <= pc_d;
            sav_q   <= sav_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: a vector request is only accepted in RUN
    always_comb begin
        state_d = state_q;
        vsel_d  = vsel_q;
        case (state_q)
            RUN: begin
                if (vec_req) begin
                    state_d = VEC0;
                    vsel_d  = vec_sel;
                end
            end
            VEC0:    state_d = VEC1;
            VEC1:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output logic: steer adder operands from the op or the vector sequencer
    always_comb begin
        add_a  = ab_q;
        add_b  = '0;
        add_ci = 1'b0;
        case (state_q)
            VEC0: begin
                add_a = VEC_BASE;
                add_b = WIDTH'({vsel_q, 1'b0});
            end
            VEC1: begin
                add_ci = (VEC_INC != 0);
            end
            default: begin
                // Constant ops leave B and CI at zero so their carry is zero
                case (op)
                    OP_ZERO: add_a = '0;
                    OP_ONE:  add_a = WIDTH'(1);
                    OP_ONES: add_a = '1;
                    OP_INC:  add_ci = CI;
                    OP_DEC: begin
                        add_b  = '1;
                        add_ci = CI;
                    end
                    OP_PC: begin
                        add_a  = pc_q;
                        add_ci = CI;
                    end
                    OP_DB: begin
                        add_a  = DB;
                        add_ci = CI;
                    end
                    OP_ABDB: begin
                        add_b  = DB;
                        add_ci = CI;
                    end
                    OP_SAV: begin
                        add_a  = sav_q;
                        add_ci = CI;
                    end
                    OP_PCDB: begin
                        add_a  = pc_q;
                        add_b  = DB;
                        add_ci = CI;
                    end
                    default: ; // hold and reserved encodings keep AB
                endcase
            end
        endcase
    end

    // Register next values; vector cycles never export a carry
    always_comb begin
        CO     = add_co & (state_q == RUN);
        AD     = add_sum;
        ab_d   = add_sum;
        co_d   = CO;
        pc_d   = ld_pc  ? (ab_q + WIDTH'(inc_pc)) : pc_q;
        sav_d  = ld_sav ? ab_q : sav_q;
        busy_d = (state_d != RUN);
    end

    assign AB   = ab_q;
    assign PC   = pc_q;
    assign SAV  = sav_q;
    assign CO_Q = co_q;
    assign busy = busy_q;

endmodule : adr_unit
`default_nettype wire

// File: tb/tb_adr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_adr_unit                                            |
// | Description : Self-checking bench for adr_unit (low-half instance).  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_adr_unit;

    logic       clk;
    logic       rst_n;
    logic       CI;
    logic [7:0] DB;
    logic [3:0] op;
    logic       ld_pc;
    logic       inc_pc;
    logic       ld_sav;
    logic       vec_req;
    logic [1:0] vec_sel;
    logic [7:0] AD;
    logic [7:0] AB;
    logic [7:0] PC;
    logic [7:0] SAV;
    logic       CO;
    logic       CO_Q;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Scoreboard of AB values expected after the next clock edge
    logic [7:0] sb_q[$];

    adr_unit #(
        .WIDTH    (8),
        .RST_PC   (8'h34),
        .VEC_BASE (8'hFA),
        .VEC_INC  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .CI      (CI),
        .DB      (DB),
        .op      (op),
        .ld_pc   (ld_pc),
        .inc_pc  (inc_pc),
        .ld_sav  (ld_sav),
        .vec_req (vec_req),
        .vec_sel (vec_sel),
        .AD      (AD),
        .AB      (AB),
        .PC      (PC),
        .SAV     (SAV),
        .CO      (CO),
        .CO_Q    (CO_Q),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pop the scoreboard and compare against the registered AB
    task automatic sb_check_ab(input string name);
        logic [7:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, AB=%02h", name, AB);
        end else begin
            exp = sb_q.pop_front();
            if (AB !== exp) begin
                errors++;
                $display("FAIL %s: AB got %02h expected %02h", name, AB, exp);
            end
        end
    endtask

    // Independent reference for the RUN-state op mux, {CO, AD}
    function automatic logic [8:0] model_ad(input logic [3:0] o, input logic [7:0] ab,
                                            input logic [7:0] pc, input logic [7:0] sav,
                                            input logic [7:0] db, input logic ci);
        logic [8:0] c;
        c = {8'h00, ci};
        case (o)
            4'h0:    return 9'h000;
            4'h1:    return 9'h001;
            4'h2:    return 9'h0FF;
            4'h4:    return {1'b0, ab} + c;
            4'h5:    return {1'b0, ab} + 9'h0FF + c;
            4'h6:    return {1'b0, pc} + c;
            4'h7:    return {1'b0, db} + c;
            4'h8:    return {1'b0, ab} + {1'b0, db} + c;
            4'h9:    return {1'b0, sav} + c;
            4'hA:    return {1'b0, pc} + {1'b0, db} + c;
            default: return {1'b0, ab};
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (AB !== 8'h00)  begin errors++; $display("FAIL reset_ab: got %02h expected 00", AB); end
        checks++; if (PC !== 8'h34)  begin errors++; $display("FAIL reset_pc: got %02h expected 34", PC); end
        checks++; if (SAV !== 8'h00) begin errors++; $display("FAIL reset_sav: got %02h expected 00", SAV); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (CO_Q !== 1'b0) begin errors++; $display("FAIL reset_coq: got %b expected 0", CO_Q); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_indexed;
        op = 4'b0111; DB = 8'hF0; CI = 1'b0;
        sb_q.push_back(8'hF0);
        tick();
        sb_check_ab("idx_setup");
        op = 4'b1000; DB = 8'h20; CI = 1'b1;
        sb_q.push_back(8'h11);
        #1;
        checks++; if (AD !== 8'h11) begin errors++; $display("FAIL idx_ad: got %02h expected 11", AD); end
        checks++; if (CO !== 1'b1)  begin errors++; $display("FAIL idx_co: got %b expected 1", CO); end
        tick();
        sb_check_ab("idx_ab");
        checks++; if (CO_Q !== 1'b1) begin errors++; $display("FAIL idx_coq: got %b expected 1", CO_Q); end
    endtask

    task automatic test_decrement;
        op = 4'b0000; CI = 1'b1;
        sb_q.push_back(8'h00);
        tick();
        sb_check_ab("dec_setup");
        op = 4'b0101; CI = 1'b0;
        #1;
        checks++; if (AD !== 8'hFF) begin errors++; $display("FAIL dec_ad: got %02h expected FF", AD); end
        checks++; if (CO !== 1'b0)  begin errors++; $display("FAIL dec_co: got %b expected 0", CO); end
        op = 4'b0010; CI = 1'b1;
        #1;
        checks++; if (AD !== 8'hFF) begin errors++; $display("FAIL ones_ad: got %02h expected FF", AD); end
        checks++; if (CO !== 1'b0)  begin errors++; $display("FAIL ones_co: got %b expected 0", CO); end
        sb_q.push_back(8'hFF);
        tick();
        sb_check_ab("ones_ab");
    endtask

    task automatic test_pc_sav;
        op = 4'b0111; DB = 8'h7F; CI = 1'b0;
        sb_q.push_back(8'h7F);
        tick();
        sb_check_ab("pcsav_setup");
        op = 4'b0011; ld_pc = 1'b1; inc_pc = 1'b1; ld_sav = 1'b1;
        sb_q.push_back(8'h7F);
        tick();
        ld_pc = 1'b0; inc_pc = 1'b0; ld_sav = 1'b0;
        sb_check_ab("pcsav_hold");
        checks++; if (PC !== 8'h80)  begin errors++; $display("FAIL pc_load: got %02h expected 80", PC); end
        checks++; if (SAV !== 8'h7F) begin errors++; $display("FAIL sav_load: got %02h expected 7F", SAV); end
    endtask

    task automatic test_vector;
        logic [7:0] vbase;
        for (int s = 0; s < 4; s++) begin
            vbase = 8'hFA + 8'(2 * s);
            // RUN cycle still executes its op
            op = 4'b0111; DB = 8'h55; CI = 1'b0; vec_req = 1'b1; vec_sel = 2'(s);
            sb_q.push_back(8'h55);
            #1;
            checks++; if (AD !== 8'h55) begin errors++; $display("FAIL vec_run_ad[%0d]: got %02h expected 55", s, AD); end
            tick();
            sb_check_ab("vec_run_ab");
            // VEC0: op toggles, vec_req dropped
            op = 4'b0000; vec_req = 1'b0; CI = 1'b1;
            sb_q.push_back(vbase);
            #1;
            checks++; if (AD !== vbase) begin errors++; $display("FAIL vec0_ad[%0d]: got %02h expected %02h", s, AD, vbase); end
            checks++; if (CO !== 1'b0)  begin errors++; $display("FAIL vec0_co[%0d]: got %b expected 0", s, CO); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec0_busy[%0d]: got %b expected 1", s, busy); end
            tick();
            sb_check_ab("vec0_ab");
            // VEC1: a new vec_req here must be ignored
            op = 4'b0001; vec_req = 1'b1;
            sb_q.push_back(vbase + 8'h01);
            #1;
            checks++; if (CO !== 1'b0)   begin errors++; $display("FAIL vec1_co[%0d]: got %b expected 0", s, CO); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec1_busy[%0d]: got %b expected 1", s, busy); end
            tick();
            sb_check_ab("vec1_ab");
            vec_req = 1'b0; op = 4'b0011;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vec_done_busy[%0d]: got %b expected 0", s, busy); end
            sb_q.push_back(vbase + 8'h01);
            tick();
            sb_check_ab("vec_after_ab");
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vec_drop_busy[%0d]: got %b expected 0", s, busy); end
        end
    endtask

    task automatic test_reset_mid_vector;
        op = 4'b0011; vec_req = 1'b1; vec_sel = 2'd1;
        tick();
        vec_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (AB !== 8'h00)  begin errors++; $display("FAIL midrst_ab: got %02h expected 00", AB); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (PC !== 8'h34)  begin errors++; $display("FAIL midrst_pc: got %02h expected 34", PC); end
        #1;
        rst_n = 1'b1;
        op = 4'b0001; CI = 1'b0;
        sb_q.push_back(8'h01);
        #1;
        checks++; if (AD !== 8'h01) begin errors++; $display("FAIL midrst_ad: got %02h expected 01", AD); end
        tick();
        sb_check_ab("midrst_ab_after");
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_random_ops;
        logic [7:0] m_ab, m_pc, m_sav;
        logic       m_coq;
        logic [8:0] r;
        m_ab = 8'h01; m_pc = 8'h34; m_sav = 8'h00; m_coq = 1'b0;
        for (int i = 0; i < 80; i++) begin
            op     = 4'($urandom_range(0, 15));
            DB     = 8'($urandom);
            CI     = 1'($urandom);
            ld_pc  = ($urandom_range(0, 3) == 0);
            inc_pc = 1'($urandom);
            ld_sav = ($urandom_range(0, 3) == 0);
            r = model_ad(op, m_ab, m_pc, m_sav, DB, CI);
            sb_q.push_back(r[7:0]);
            #1;
            checks++; if (AD !== r[7:0]) begin errors++; $display("FAIL rnd_ad[%0d] op=%h: got %02h expected %02h", i, op, AD, r[7:0]); end
            checks++; if (CO !== r[8])   begin errors++; $display("FAIL rnd_co[%0d] op=%h: got %b expected %b", i, op, CO, r[8]); end
            if (ld_pc)  m_pc  = m_ab + {7'd0, inc_pc};
            if (ld_sav) m_sav = m_ab;
            m_ab  = r[7:0];
            m_coq = r[8];
            tick();
            sb_check_ab("rnd_ab");
            checks++; if (PC !== m_pc)    begin errors++; $display("FAIL rnd_pc[%0d]: got %02h expected %02h", i, PC, m_pc); end
            checks++; if (SAV !== m_sav)  begin errors++; $display("FAIL rnd_sav[%0d]: got %02h expected %02h", i, SAV, m_sav); end
            checks++; if (CO_Q !== m_coq) begin errors++; $display("FAIL rnd_coq[%0d]: got %b expected %b", i, CO_Q, m_coq); end
        end
        ld_pc = 1'b0; inc_pc = 1'b0; ld_sav = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; CI = 1'b0; DB = 8'h00; op = 4'b0011;
        ld_pc = 1'b0; inc_pc = 1'b0; ld_sav = 1'b0; vec_req = 1'b0; vec_sel = 2'd0;
        test_reset();
        test_indexed();
        test_decrement();
        test_pc_sav();
        test_vector();
        test_reset_mid_vector();
        test_random_ops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adr_unit
`default_nettype wire
